// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes and the multu_seq FSM state type.
package alu_pkg;

  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } multuState_e;

endpackage

// File: rtl/multu_datapath.sv
// multu_datapath: shift-add core holding multiplicand, upper accumulator and multiplier.
// prodNext is the product after the current step, so the final step can be committed on its own edge.
module multu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [2*WIDTH-1:0] prodNext
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic [WIDTH:0]   sum;

  // The carry-out lands in the accumulator MSB after the right shift, so no bit is lost.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = sum[WIDTH:1];
    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
    prodNext = {acc_d, mplier_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (load) begin
      mcand_q  <= dataA;
      acc_q    <= '0;
      mplier_q <= dataB;
    end else if (step) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/multu_seq.sv
// multu_seq: sequential unsigned multiplier, one shift-add step per cycle, result in hi/lo.
// Optional macro MULTU_EARLY_TERM_EN: a zero operand skips RUN and commits zero immediately.
module multu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  multuState_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               accept;
  logic               step;
  logic [2*WIDTH-1:0] prodNext;

  assign accept = (state_q == ST_IDLE) && start && (signal == FN_MULTU) && !reset;
  assign step   = (state_q == ST_RUN) && !reset;

  multu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .dataA    (dataA),
    .dataB    (dataB),
    .prodNext (prodNext)
  );

  // hi/lo only change on the edge of the final step, so partial products never show.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
`ifdef MULTU_EARLY_TERM_EN
            if ((dataA == '0) || (dataB == '0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hi_q    <= '0;
              lo_q    <= '0;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
`else
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LastStep) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= prodNext;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
